// File: rtl/core_reset_ctrl.sv
// core_reset_ctrl: sequences a reset pulse to downstream domains, waits for
// every domain to report reset exit, and reports completion or timeout.
// Loss of PLL lock restarts the sequence from any state.
module core_reset_ctrl #(
  parameter int NUM_DOMAINS  = 1,
  parameter int PULSE_CLKS   = 16,
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_srst,
  input  logic                   i_pll_locked,
  input  logic                   i_sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] i_domain_in_reset,
  output logic                   o_rst_req,
  output logic                   o_busy,
  output logic                   o_rst_done,
  output logic                   o_timeout
);

  localparam int PW = $clog2(PULSE_CLKS) + 1;
  localparam int TW = $clog2(TIMEOUT_CLKS) + 1;

  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CLKS - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_EXIT = 2'd1,
    ST_IDLE      = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          rst_req_q, rst_req_d;
  logic          rst_done_q, rst_done_d;
  logic          timeout_q, timeout_d;
  logic          all_clear;

  // Saturating increments: counters stop at all-ones instead of wrapping.
  function automatic logic [PW-1:0] pulse_inc(input logic [PW-1:0] v);
    return (v == {PW{1'b1}}) ? v : v + PW'(1);
  endfunction

  function automatic logic [TW-1:0] to_inc(input logic [TW-1:0] v);
    return (v == {TW{1'b1}}) ? v : v + TW'(1);
  endfunction

  assign all_clear = (i_domain_in_reset == '0);

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    to_cnt_d    = to_cnt_q;
    rst_done_d  = 1'b0;
    timeout_d   = timeout_q;

    case (state_q)
      ST_ASSERT: begin
        if (!i_pll_locked) begin
          // Unlocked cycles do not count toward the pulse width.
          pulse_cnt_d = '0;
        end else if (pulse_cnt_q >= PULSE_LAST) begin
          state_d     = ST_WAIT_EXIT;
          pulse_cnt_d = '0;
          to_cnt_d    = '0;
        end else begin
          pulse_cnt_d = pulse_inc(pulse_cnt_q);
        end
      end

      ST_WAIT_EXIT: begin
        // Lock loss outranks a software restart, which outranks completion.
        if (!i_pll_locked || i_sw_rst_req) begin
          state_d     = ST_ASSERT;
          pulse_cnt_d = '0;
          to_cnt_d    = '0;
          timeout_d   = 1'b0;
        end else if (all_clear) begin
          // Success wins even on the cycle the timeout would expire.
          state_d    = ST_IDLE;
          to_cnt_d   = '0;
          rst_done_d = 1'b1;
        end else if (to_cnt_q >= TO_LAST) begin
          state_d   = ST_IDLE;
          to_cnt_d  = '0;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_inc(to_cnt_q);
        end
      end

      ST_IDLE: begin
        if (!i_pll_locked || i_sw_rst_req) begin
          state_d     = ST_ASSERT;
          pulse_cnt_d = '0;
          to_cnt_d    = '0;
          timeout_d   = 1'b0;
        end
      end

      default: begin
        state_d     = ST_ASSERT;
        pulse_cnt_d = '0;
        to_cnt_d    = '0;
        timeout_d   = 1'b0;
      end
    endcase

    rst_req_d = (state_d == ST_ASSERT);
  end

  // State and output registers; reset parks the controller in ASSERT.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q     <= ST_ASSERT;
      pulse_cnt_q <= '0;
      to_cnt_q    <= '0;
      rst_req_q   <= 1'b1;
      rst_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      to_cnt_q    <= to_cnt_d;
      rst_req_q   <= rst_req_d;
      rst_done_q  <= rst_done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_rst_req  = rst_req_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_rst_done = rst_done_q;
  assign o_timeout  = timeout_q;

endmodule

// File: doc/core_reset_ctrl.md
CORE_RESET_CTRL -- requirements
Module: core_reset_ctrl

Interface
REQ-001 Parameter NUM_DOMAINS, default 1: number of downstream reset domains monitored (>=1).
REQ-002 Parameter PULSE_CLKS, default 16: clocks o_rst_req is held high per sequence (>=1).
REQ-003 Parameter TIMEOUT_CLKS, default 1024: max clocks to wait for all domains to exit reset (>=1).
REQ-004 i_clk  input  1  single clock; all logic on rising edge.
REQ-005 i_srst  input  1  reset; synchronous, active-high.
REQ-006 i_pll_locked  input  1  lock status of PLLs feeding downstream domains; synchronous to i_clk.
REQ-007 i_sw_rst_req  input  1  one-cycle software request for a full reset sequence.
REQ-008 i_domain_in_reset  input  NUM_DOMAINS  per-domain "still in reset" status, pre-synchronized to i_clk by the integrator.
REQ-009 o_rst_req  output  1  reset request driving downstream external asynchronous reset inputs.
REQ-010 o_busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 o_rst_done  output  1  one-cycle pulse on successful sequence completion.
REQ-012 o_timeout  output  1  sticky flag: last sequence timed out.

Function
REQ-013 FSM SHALL have exactly three states: ASSERT, WAIT_EXIT, IDLE.
REQ-014 ASSERT: o_rst_req=1; pulse counter SHALL increment once per cycle only while i_pll_locked=1; SHALL be held at 0 while i_pll_locked=0.
REQ-015 ASSERT -> WAIT_EXIT when the pulse counter reaches PULSE_CLKS-1 with i_pll_locked=1; o_rst_req SHALL be high for exactly PULSE_CLKS consecutive locked cycles.
REQ-016 On entry to WAIT_EXIT, o_rst_req SHALL be 0 and the timeout counter SHALL be 0.
REQ-017 WAIT_EXIT: when i_domain_in_reset is all-zero, the FSM SHALL go to IDLE and o_rst_done SHALL pulse high for exactly one cycle, registered, in the cycle after that sample.
REQ-018 WAIT_EXIT: the timeout counter SHALL increment each cycle; when it reaches TIMEOUT_CLKS-1 without all-zero status, the FSM SHALL go to IDLE, set o_timeout=1, and SHALL NOT pulse o_rst_done.
REQ-019 All-zero status and timeout in the same cycle: success SHALL take priority (o_rst_done pulses, o_timeout unchanged).
REQ-020 IDLE: o_rst_req=0; i_sw_rst_req=1 SHALL move the FSM to ASSERT next cycle with the pulse counter cleared.
REQ-021 i_sw_rst_req SHALL be ignored in ASSERT; in WAIT_EXIT it SHALL restart the sequence (-> ASSERT, counters cleared).
REQ-022 i_pll_locked=0 in WAIT_EXIT or IDLE SHALL force ASSERT next cycle with counters cleared; loss of lock has priority over i_sw_rst_req and over success/timeout.
REQ-023 o_timeout SHALL clear on every entry to ASSERT.
REQ-024 Counter widths SHALL be $clog2 of the respective parameter plus 1; counters SHALL saturate and never wrap.
REQ-025 o_busy SHALL be combinationally (state != IDLE).
REQ-026 All outputs except o_busy SHALL be registered; no combinational input-to-output path.

Reset
REQ-027 While i_srst=1: state=ASSERT, both counters=0, o_rst_req=1, o_busy=1, o_rst_done=0, o_timeout=0.
REQ-028 i_srst asserted mid-sequence SHALL override all other inputs and restart from ASSERT in the next cycle.
REQ-029 After i_srst deasserts, a power-on sequence SHALL run automatically (no i_sw_rst_req needed).

Verification
REQ-030 PULSE_CLKS=4, lock=1, release i_srst, domains clear 3 clocks after o_rst_req falls -> o_rst_req high exactly 4 cycles; o_rst_done one pulse; o_busy low afterwards.
REQ-031 TIMEOUT_CLKS=8, domain[0] stuck at 1 -> after 8 WAIT_EXIT cycles state=IDLE, o_timeout=1, no o_rst_done; next i_sw_rst_req clears o_timeout.
REQ-032 Lock low for 10 cycles during ASSERT after 2 counted cycles -> o_rst_req held high; after relock, exactly PULSE_CLKS further high cycles.
REQ-033 i_sw_rst_req in IDLE, again in ASSERT, again in WAIT_EXIT -> ASSERT-phase request has no effect; WAIT_EXIT request reissues a full PULSE_CLKS pulse.
REQ-034 NUM_DOMAINS=3, domains clearing at different times, last clears in the same cycle the timeout expires -> o_rst_done pulses, o_timeout stays 0.
REQ-035 i_srst pulsed during WAIT_EXIT -> outputs take reset values next cycle; full new sequence follows.
